// File: rtl/linear_regressor_param.sv
// linear_regressor_param: buffers signed (x,y) samples, fits y = b1*x + b0 in Q(FRAC), streams residuals
// Ports: clk/rst (async, active-low); start/clear control; in_valid/in_ready/x_in/y_in sample input;
// busy/ready status; coef_valid/b1/b0/deg fit result; err_valid/err_ready/err_out/err_idx residual stream;
// sse sum of squared residuals, only when LR_SSE_EN is defined (otherwise tied to 0).
module linear_regressor_param #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int FRAC  = 8,
  parameter int EW    = 20,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = 2*DW + FRAC + AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] x_in,
  input  logic signed [DW-1:0] y_in,
  output logic                 busy,
  output logic                 coef_valid,
  output logic signed [CW-1:0] b1,
  output logic signed [CW-1:0] b0,
  output logic                 deg,
  output logic                 err_valid,
  input  logic                 err_ready,
  output logic signed [EW-1:0] err_out,
  output logic [AW-1:0]        err_idx,
  output logic [2*EW-1:0]      sse,
  output logic                 ready
);
  localparam int QW  = CW + AW;
  localparam int SW  = 2*DW + AW + 1;
  localparam int LW  = QW + 2;
  localparam int RW  = CW + DW + 2;
  localparam int CNW = $clog2(QW + 1);
  typedef enum logic [2:0] {IDLE, SUM, PREP, DIV1, DIV2, ERR, DONE} state_t;
  state_t state_q, state_d;
  logic signed [DW-1:0] mem_x [DEPTH];
  logic signed [DW-1:0] mem_y [DEPTH];
  logic [AW:0] n_q, n_d;
  logic [AW-1:0] idx_q, idx_d, ri, err_idx_q, err_idx_d;
  logic [CNW-1:0] cnt_q, cnt_d;
  logic signed [SW-1:0] sx_q, sx_d, sy_q, sy_d, sxx_q, sxx_d, sxy_q, sxy_d;
  logic signed [LW-1:0] num_q, num_d, den_q, den_d, n_s, sxl, syl, la, lb, la_b0;
  logic [QW-1:0] quo_q, quo_d, dvs_q, dvs_d, rem_q, rem_d;
  logic [QW:0] rs;
  logic neg_q, neg_d, ge, ld, acc, start_acc, xfer, last;
  logic in_ready_q, in_ready_d, busy_q, busy_d, coef_valid_q, coef_valid_d;
  logic deg_q, deg_d, err_valid_q, err_valid_d, ready_q, ready_d;
  logic signed [CW-1:0] b1_q, b1_d, b0_q, b0_d, q_mag, q_fix, b1_new;
  logic signed [EW-1:0] err_out_q, err_out_d, res;
  logic signed [RW-1:0] diff, sh;
`ifdef LR_SSE_EN
  logic [2*EW-1:0] sse_q, sse_d;
  logic signed [2*EW-1:0] sq;
`endif

  always_ff @(posedge clk) begin
    if (acc) begin
      mem_x[n_q[AW-1:0]] <= x_in;
      mem_y[n_q[AW-1:0]] <= y_in;
    end
  end

  always_comb begin
    acc = state_q == IDLE && !clear && in_valid && in_ready_q;
    start_acc = state_q == IDLE && !clear && start;
    xfer = err_valid_q && err_ready;
    last = {1'b0, idx_q} == n_q - (AW+1)'(1);
    n_s = LW'(n_q);
    sxl = LW'(sx_q);
    syl = LW'(sy_q);
    // residual for the entry about to be presented: current one on first load, next one after a transfer
    ri = err_valid_q ? idx_q + AW'(1) : idx_q;
    diff = (RW'(mem_y[ri]) <<< FRAC) - (RW'(b1_q) * RW'(mem_x[ri]) + RW'(b0_q));
    sh = diff >>> FRAC;
    res = (&sh[RW-1:EW-1] || ~|sh[RW-1:EW-1]) ? sh[EW-1:0] : {sh[RW-1], {(EW-1){~sh[RW-1]}}};
    rs = {rem_q, quo_q[QW-1]};
    ge = rs >= {1'b0, dvs_q};
    q_mag = CW'(quo_q);
    q_fix = neg_q ? -q_mag : q_mag;
    b1_new = state_q == DIV1 ? q_fix : '0;
    la_b0 = (syl <<< FRAC) - LW'(b1_new) * sxl;
    state_d = state_q;
    n_d = n_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    sx_d = sx_q;
    sy_d = sy_q;
    sxx_d = sxx_q;
    sxy_d = sxy_q;
    num_d = num_q;
    den_d = den_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    rem_d = rem_q;
    neg_d = neg_q;
    coef_valid_d = coef_valid_q;
    deg_d = deg_q;
    b1_d = b1_q;
    b0_d = b0_q;
    err_valid_d = err_valid_q;
    err_out_d = err_out_q;
    err_idx_d = err_idx_q;
    ld = 1'b0;
    la = '0;
    lb = '0;
    case (state_q)
      IDLE: begin
        n_d = clear ? '0 : acc ? n_q + (AW+1)'(1) : n_q;
        if (start_acc) begin
          state_d = n_d == '0 ? PREP : SUM;
          sx_d = '0;
          sy_d = '0;
          sxx_d = '0;
          sxy_d = '0;
          idx_d = '0;
          cnt_d = '0;
          coef_valid_d = 1'b0;
          deg_d = 1'b0;
          b1_d = '0;
          b0_d = '0;
        end
      end
      SUM: begin
        sx_d = sx_q + SW'(mem_x[idx_q]);
        sy_d = sy_q + SW'(mem_y[idx_q]);
        sxx_d = sxx_q + SW'(mem_x[idx_q]) * SW'(mem_x[idx_q]);
        sxy_d = sxy_q + SW'(mem_x[idx_q]) * SW'(mem_y[idx_q]);
        idx_d = last ? '0 : idx_q + AW'(1);
        state_d = last ? PREP : SUM;
      end
      PREP: begin
        num_d = n_s * LW'(sxy_q) - sxl * syl;
        den_d = n_s * LW'(sxx_q) - sxl * sxl;
        cnt_d = CNW'(1);
        if (cnt_q != '0) begin
          cnt_d = '0;
          if (n_q == '0) begin
            state_d = DONE;
            deg_d = 1'b1;
            coef_valid_d = 1'b1;
          end else if (den_q == '0) begin
            state_d = DIV2;
            deg_d = 1'b1;
            ld = 1'b1;
            la = la_b0;
            lb = n_s;
          end else begin
            state_d = DIV1;
            ld = 1'b1;
            la = num_q <<< FRAC;
            lb = den_q;
          end
        end
      end
      DIV1, DIV2: begin
        if (cnt_q != CNW'(QW)) begin
          rem_d = QW'(ge ? rs - {1'b0, dvs_q} : rs);
          quo_d = {quo_q[QW-2:0], ge};
          cnt_d = cnt_q + CNW'(1);
        end else if (state_q == DIV1) begin
          b1_d = q_fix;
          state_d = DIV2;
          ld = 1'b1;
          la = la_b0;
          lb = n_s;
        end else begin
          b0_d = q_fix;
          coef_valid_d = 1'b1;
          idx_d = '0;
          state_d = ERR;
        end
      end
      ERR: begin
        if (!err_valid_q || (xfer && !last)) begin
          err_valid_d = 1'b1;
          err_out_d = res;
          err_idx_d = ri;
          idx_d = ri;
        end else if (xfer) begin
          err_valid_d = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // divider load: magnitudes into the shift register, sign applied after the last quotient bit
    if (ld) begin
      neg_d = la[LW-1] ^ lb[LW-1];
      quo_d = QW'(la[LW-1] ? -la : la);
      dvs_d = QW'(lb[LW-1] ? -lb : lb);
      rem_d = '0;
      cnt_d = '0;
    end
    in_ready_d = state_d == IDLE && !n_d[AW];
    busy_d = state_d != IDLE;
    ready_d = state_d == DONE;
`ifdef LR_SSE_EN
    sq = (2*EW)'(err_out_q) * (2*EW)'(err_out_q);
    sse_d = start_acc ? '0 : (state_q == ERR && xfer) ? sse_q + unsigned'(sq) : sse_q;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      n_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      sx_q <= '0;
      sy_q <= '0;
      sxx_q <= '0;
      sxy_q <= '0;
      num_q <= '0;
      den_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      neg_q <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q <= 1'b0;
      coef_valid_q <= 1'b0;
      deg_q <= 1'b0;
      b1_q <= '0;
      b0_q <= '0;
      err_valid_q <= 1'b0;
      err_out_q <= '0;
      err_idx_q <= '0;
      ready_q <= 1'b0;
`ifdef LR_SSE_EN
      sse_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      sxx_q <= sxx_d;
      sxy_q <= sxy_d;
      num_q <= num_d;
      den_q <= den_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      rem_q <= rem_d;
      neg_q <= neg_d;
      in_ready_q <= in_ready_d;
      busy_q <= busy_d;
      coef_valid_q <= coef_valid_d;
      deg_q <= deg_d;
      b1_q <= b1_d;
      b0_q <= b0_d;
      err_valid_q <= err_valid_d;
      err_out_q <= err_out_d;
      err_idx_q <= err_idx_d;
      ready_q <= ready_d;
`ifdef LR_SSE_EN
      sse_q <= sse_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign busy = busy_q;
  assign coef_valid = coef_valid_q;
  assign deg = deg_q;
  assign b1 = b1_q;
  assign b0 = b0_q;
  assign err_valid = err_valid_q;
  assign err_out = err_out_q;
  assign err_idx = err_idx_q;
  assign ready = ready_q;
`ifdef LR_SSE_EN
  assign sse = sse_q;
`else
  assign sse = '0;
`endif
endmodule

// File: tb/tb_linear_regressor_param.sv
// tb_linear_regressor_param: scoreboard bench for linear_regressor_param
module tb_linear_regressor_param;
  localparam int DW = 8, DEPTH = 16, FRAC = 8, EW = 20, AW = 4, CW = 2*DW + FRAC + AW;
  logic clk = 0, rst = 0, start = 0, clear = 0, in_valid = 0, err_ready = 0;
  logic signed [DW-1:0] x_in = 0, y_in = 0;
  logic in_ready, busy, coef_valid, deg, err_valid, ready;
  logic signed [CW-1:0] b1, b0;
  logic signed [EW-1:0] err_out;
  logic [AW-1:0] err_idx;
  logic [2*EW-1:0] sse;
  int vectors = 0, miscompares = 0;
  int mx [DEPTH];
  int my [DEPTH];
  int mn = 0;
  longint exp_b1, exp_b0, exp_sse, exp_deg;
  longint res_q [$];
  longint idx_q [$];

  always #5 clk = ~clk;

  linear_regressor_param dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .busy(busy), .coef_valid(coef_valid), .b1(b1), .b0(b0), .deg(deg),
    .err_valid(err_valid), .err_ready(err_ready), .err_out(err_out), .err_idx(err_idx), .sse(sse),
    .ready(ready)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1;
    step();
    clear = 0;
    mn = 0;
  endtask

  task automatic push(input int x, input int y);
    in_valid = 1;
    x_in = DW'(x);
    y_in = DW'(y);
    check($sformatf("in_ready@%0d", mn), in_ready, mn < DEPTH);
    if (mn < DEPTH) begin
      mx[mn] = x;
      my[mn] = y;
      mn++;
    end
    step();
    in_valid = 0;
  endtask

  task automatic model();
    longint sx = 0, sy = 0, sxx = 0, sxy = 0, num, den, r;
    res_q.delete();
    idx_q.delete();
    exp_sse = 0;
    for (int i = 0; i < mn; i++) begin
      sx += mx[i];
      sy += my[i];
      sxx += mx[i] * mx[i];
      sxy += mx[i] * my[i];
    end
    num = mn * sxy - sx * sy;
    den = mn * sxx - sx * sx;
    exp_deg = (mn == 0 || den == 0) ? 1 : 0;
    exp_b1 = exp_deg != 0 ? 0 : (num * 256) / den;
    exp_b0 = mn == 0 ? 0 : (sy * 256 - exp_b1 * sx) / mn;
    for (int i = 0; i < mn; i++) begin
      r = (longint'(my[i]) * 256 - (exp_b1 * mx[i] + exp_b0)) >>> FRAC;
      if (r > 524287) r = 524287;
      if (r < -524288) r = -524288;
      res_q.push_back(r);
      idx_q.push_back(i);
      exp_sse += r * r;
    end
`ifndef LR_SSE_EN
    exp_sse = 0;
`endif
  endtask

  // exp_cycle >= 0: ready must appear in that cycle, counting the start cycle as cycle 1
  task automatic run(input string tag, input bit bp, input int exp_cycle);
    int stall = 0;
    bit got = 0;
    model();
    start = 1;
    step();
    start = 0;
    in_valid = 0;
    for (int c = 0; c < 2000 && !got; c++) begin
      err_ready = !(bp && err_valid && err_idx == 1 && stall < 5);
      if (!err_ready) stall++;
      @(negedge clk);
      if (c == 0) begin
        check({tag, ".busy"}, busy, 1);
        check({tag, ".coef_cleared"}, coef_valid, 0);
      end
      if (err_valid && !err_ready && res_q.size() > 0) begin
        check({tag, ".held_err"}, err_out, res_q[0]);
        check({tag, ".held_idx"}, err_idx, idx_q[0]);
      end
      if (err_valid && err_ready) begin
        if (res_q.size() == 0) check({tag, ".extra_residual_idx"}, err_idx, -1);
        else begin
          check({tag, ".idx"}, err_idx, idx_q.pop_front());
          check({tag, ".err"}, err_out, res_q.pop_front());
        end
      end
      if (ready) begin
        got = 1;
        if (exp_cycle >= 0) check({tag, ".ready_cycle"}, c + 2, exp_cycle);
        check({tag, ".b1"}, b1, exp_b1);
        check({tag, ".b0"}, b0, exp_b0);
        check({tag, ".deg"}, deg, exp_deg);
        check({tag, ".coef_valid"}, coef_valid, 1);
        check({tag, ".sse"}, longint'(sse), exp_sse);
        check({tag, ".missing_residuals"}, res_q.size(), 0);
      end
      @(posedge clk);
      #1;
    end
    check({tag, ".ready_seen"}, got, 1);
    if (bp) check({tag, ".stall_cycles"}, stall, 5);
    err_ready = 0;
    @(negedge clk);
    check({tag, ".ready_one_cycle"}, ready, 0);
    check({tag, ".idle"}, busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst.in_ready", in_ready, 1);
    check("rst.busy", busy, 0);
    check("rst.coef_valid", coef_valid, 0);
    check("rst.b1", b1, 0);
    check("rst.b0", b0, 0);
    check("rst.deg", deg, 0);
    check("rst.err_valid", err_valid, 0);
    check("rst.err_out", err_out, 0);
    check("rst.err_idx", err_idx, 0);
    check("rst.sse", longint'(sse), 0);
    check("rst.ready", ready, 0);
    @(posedge clk);
    #1;
    rst = 1;
    step();
    // line fit y = 2x + 1, then repeat on the same buffer with backpressure
    for (int i = 0; i < 4; i++) push(i, 2 * i + 1);
    run("line", 0, -1);
    check("line.b1_q8", b1, 512);
    check("line.b0_q8", b0, 256);
    run("line_bp", 1, -1);
    // zero x-variance: b1 forced to 0, b0 is the mean of y
    do_clear();
    push(3, 2);
    push(3, 4);
    run("degen", 0, -1);
    check("degen.b0_q8", b0, 768);
    // empty buffer
    do_clear();
    run("empty", 0, 4);
    // full buffer: the 17th sample must be dropped
    do_clear();
    for (int i = 0; i < 16; i++) push(i - 8, int'($urandom_range(0, 255)) - 128);
    push(100, -100);
    run("full", 0, -1);
    // sample and start in the same cycle after a clear
    do_clear();
    in_valid = 1;
    x_in = 5;
    y_in = 9;
    mx[0] = 5;
    my[0] = 9;
    mn = 1;
    run("same_cycle", 0, -1);
    check("same_cycle.b0_q8", b0, 2304);
    // random data sets
    for (int t = 0; t < 3; t++) begin
      do_clear();
      for (int i = 0; i < int'($urandom_range(2, 16)); i++)
        push(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
      run($sformatf("rand%0d", t), t == 1, -1);
    end
    // asynchronous reset in the middle of the slope division
    do_clear();
    for (int i = 0; i < 4; i++) push(i, 2 * i + 1);
    start = 1;
    step();
    start = 0;
    repeat (10) step();
    check("mid.busy", busy, 1);
    rst = 0;
    #1;
    check("mid.in_ready", in_ready, 1);
    check("mid.busy_clr", busy, 0);
    check("mid.coef_valid", coef_valid, 0);
    check("mid.b1", b1, 0);
    check("mid.b0", b0, 0);
    check("mid.deg", deg, 0);
    check("mid.err_valid", err_valid, 0);
    check("mid.err_out", err_out, 0);
    check("mid.sse", longint'(sse), 0);
    check("mid.ready", ready, 0);
    step();
    rst = 1;
    mn = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid.no_ready", ready, 0);
      @(posedge clk);
      #1;
    end
    run("mid_empty", 0, 4);
    for (int i = 0; i < 4; i++) push(i, 2 * i + 1);
    run("post_reset", 0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/linear_regressor_param.md
Name: linear_regressor_param

Overview:
- Parametrised successor to the fixed-size linear regressor.
- Buffers up to DEPTH signed (x,y) samples through a valid/ready input port. On start it computes the least-squares slope b1 and intercept b0 in fixed point, then streams per-sample residuals through a valid/ready output port.
- Sits between the sample source and the error-consumer/checker in the CA datapath.

Parameters:
- DW, 8: signed width of x and y samples.
- DEPTH, 16: sample buffer depth; power of 2, at least 2. AW = log2(DEPTH).
- FRAC, 8: fractional bits of b1 and b0.
- EW, 20: signed residual width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  begin regression on the buffered samples; honoured only in IDLE.
- clear  in  1  empty the sample buffer; honoured only in IDLE.
- in_valid  in  1  sample (x_in, y_in) offered.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- x_in  in  DW  signed sample x.
- y_in  in  DW  signed sample y.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- coef_valid  out  1  b1/b0/deg hold valid results; cleared on start.
- b1  out  CW=2*DW+FRAC+AW  signed slope, Q(FRAC).
- b0  out  CW  signed intercept, Q(FRAC).
- deg  out  1  degenerate fit: N==0 or denominator==0.
- err_valid  out  1  residual available.
- err_ready  in  1  consumer accepts the residual.
- err_out  out  EW  signed residual.
- err_idx  out  AW  index of the sample that produced err_out.
- sse  out  2*EW  sum of squared residuals; see Optional Feature.
- ready  out  1  one-cycle pulse when the run completes.

Behaviour:
- Reset:
  - All outputs are 0 and the sample count N is 0, except in_ready=1.
  - Reset in any state aborts the run; no ready pulse is produced.
- States, with occupancy:
  - IDLE
  - SUM: N cycles.
  - PREP: 2 cycles.
  - DIV1: QW+1 cycles.
  - DIV2: QW+1 cycles.
  - ERR: at least N cycles.
  - DONE: 1 cycle.
  - QW = CW + AW.
- IDLE:
  - in_ready = (N < DEPTH).
  - An accepted sample is written at address N, then N increments.
  - If in_valid and start occur in the same cycle, the sample is accepted and included in the run.
  - clear sets N=0; clear has priority over start and over in_valid.
  - When N==DEPTH, in_ready=0 and offered samples are dropped without error.
- In all states other than IDLE: in_ready=0, and start and clear are ignored.
- SUM:
  - Accumulates full-precision signed Sx, Sy, Sxx, Sxy, one sample per cycle.
  - No overflow is possible at the declared widths.
- PREP:
  - num = N*Sxy - Sx*Sy.
  - den = N*Sxx - Sx*Sx.
- DIV1:
  - Sequential restoring divider computing b1 = (num<<FRAC)/den.
  - Magnitude division, one quotient bit per cycle, then sign fix.
  - Result truncates toward zero.
- DIV2:
  - The same divider computes b0 = ((Sy<<FRAC) - b1*Sx)/N, truncating toward zero.
- Degenerate cases:
  - N==0: deg=1, b1=b0=0, coef_valid=1; go straight to DONE (no residuals).
  - den==0: deg=1, b1=0, DIV1 is skipped (0 cycles), and DIV2 and ERR run normally.
- coef_valid rises on entry to ERR and holds until the next accepted start.
- ERR:
  - For i = 0..N-1: err_out = sat_EW(((y_i<<FRAC) - (b1*x_i + b0)) >>> FRAC), where >>> is arithmetic shift (floor) and sat_EW saturates to the EW range. err_idx = i.
  - err_valid/err_out/err_idx hold stable while err_ready=0.
  - The index advances only on err_valid && err_ready.
  - Back-to-back transfers are allowed (1 residual per cycle).
- DONE: ready pulses for 1 cycle, busy drops, state returns to IDLE.
- Buffer contents and N survive a run, so start may be repeated on the same data.

Optional Feature:
- Macro: LR_SSE_EN.
- Defined:
  - sse is cleared on accepted start.
  - During ERR, sse accumulates err_out*err_out on each transfer.
  - The final value is valid from the ready pulse onward.
- Undefined: sse is tied to 0 and no squarer or accumulator is synthesised.

Test Plan:
- Line fit: load (0,1),(1,3),(2,5),(3,7), then start.
  - Expect deg=0, b1=512, b0=256, four residuals of 0 with err_idx 0..3, one ready pulse, sse=0.
- Degenerate den: load (3,2),(3,4), then start.
  - Expect deg=1, b1=0, b0=768, residuals -1 then +1, sse=2 (with LR_SSE_EN).
- Empty: start with N=0.
  - Expect deg=1, b1=b0=0, no err_valid, ready pulse 4 cycles after start.
- Backpressure: hold err_ready=0 for 5 cycles during ERR of the line-fit test.
  - Expect err_out/err_idx frozen, then residual order unchanged and nothing lost.
- Full buffer: offer 17 samples.
  - Expect in_ready=0 after the 16th; the 17th is not stored; N=16.
  - Then offer in_valid+start in the same cycle after clear: the sample is counted and N=1.
- Reset mid-DIV1: pull rst low.
  - Expect all outputs 0, in_ready=1, N=0, no ready pulse.
  - The next load and start produce correct results.
